// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM encodings and decode helpers for the boot-time
// program loader and its word packer.
package program_loader_pkg;

  localparam int unsigned StateW = 3;

  // FSM state encodings
  localparam logic [StateW-1:0] StLenHi = 3'd0;
  localparam logic [StateW-1:0] StLenLo = 3'd1;
  localparam logic [StateW-1:0] StData  = 3'd2;
  localparam logic [StateW-1:0] StDrain = 3'd3;
  localparam logic [StateW-1:0] StDone  = 3'd4;
  localparam logic [StateW-1:0] StError = 3'd5;

  // Byte stream is only consumed while reading the header or the payload.
  function automatic logic state_accepts(input logic [StateW-1:0] st);
    return (st == StLenHi) || (st == StLenLo) || (st == StData);
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// program_loader_word_packer: packs bytes MSB-first into 32-bit words.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   i_clear        - synchronous clear of the partial word and byte index
//   i_shift        - accept i_byte this cycle
//   i_byte         - payload byte
//   o_word_done    - high in the cycle the fourth byte of a word is accepted
//   o_word         - packed word, valid while o_word_done is high
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic [31:0] o_word
);

  // Only the first three bytes need storage; the fourth is merged in on the fly
  // so the top level can register the full word on the accepting edge.
  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  assign o_word_done = i_shift && (r_idx == 2'd3);
  assign o_word      = {r_shift, i_byte};

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time loader that receives a length-prefixed byte stream,
// packs it into big-endian 32-bit words, writes them to word addresses 0..N-1
// and then releases the CPU from reset.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   in_valid/in_data/in_ready - byte stream handshake
//   mem_write/mem_addr/mem_wdata - registered one-cycle memory write
//   cpu_run        - CPU may leave reset (only once loading is complete)
//   error          - sticky: declared length exceeds memory capacity
//   words_loaded   - number of words written so far
// ADDR_WIDTH must be below 32.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_run,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  logic [StateW-1:0]     r_state, w_state_next;
  logic [15:0]           r_len, w_len_next;
  logic                  r_mem_write, w_mem_write_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [31:0]           r_mem_wdata, w_mem_wdata_next;
  logic [ADDR_WIDTH:0]   r_words, w_words_next;
  logic                  r_cpu_run;

  logic        w_accept;
  logic        w_shift;
  logic        w_clear;
  logic        w_word_done;
  logic [31:0] w_word;
  logic [15:0] w_len_rx;
  logic        w_too_long;
  logic        w_last_word;

  assign in_ready = state_accepts(r_state);
  assign w_accept = in_valid && in_ready;
  assign w_shift  = w_accept && (r_state == StData);
  // Start every payload with an empty packer.
  assign w_clear  = w_accept && (r_state == StLenLo);

  // Full length as it will be once the low byte is captured.
  assign w_len_rx    = {r_len[15:8], in_data};
  assign w_too_long  = 32'(w_len_rx) > (32'd1 << ADDR_WIDTH);
  assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_len);

  program_loader_word_packer u_word_packer (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_byte      (in_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_comb begin
    w_state_next     = r_state;
    w_len_next       = r_len;
    w_mem_write_next = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_words_next     = r_words;
    case (r_state)
      StLenHi: begin
        if (w_accept) begin
          w_len_next[15:8] = in_data;
          w_state_next     = StLenLo;
        end
      end
      StLenLo: begin
        if (w_accept) begin
          w_len_next[7:0] = in_data;
          if (w_len_rx == 16'd0) begin
            w_state_next = StDrain;
          end else if (w_too_long) begin
            w_state_next = StError;
          end else begin
            w_state_next = StData;
          end
        end
      end
      StData: begin
        if (w_word_done) begin
          w_mem_write_next = 1'b1;
          // Current count is the address of the word being written.
          w_mem_addr_next  = r_words[ADDR_WIDTH-1:0];
          w_mem_wdata_next = w_word;
          w_words_next     = r_words + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (w_last_word) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        w_state_next = StDone;
      end
      default: begin
        // StDone and StError hold until reset.
        w_state_next = r_state;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StLenHi;
      r_len       <= '0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_words     <= '0;
      r_cpu_run   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_mem_write <= w_mem_write_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_words     <= w_words_next;
      // Registered one cycle behind DONE so the release trails the drain cycle.
      r_cpu_run   <= (r_state == StDone);
    end
  end

  assign mem_write    = r_mem_write;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words;
  assign cpu_run      = r_cpu_run;
  assign error        = (r_state == StError);

endmodule
